// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: micro-ops, the execute-side request,
// the FSM state encoding and the bus request/response bundles.
package load_store_unit_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_FLWS = 4'd6,
      OP_SB   = 4'd7,
      OP_SH   = 4'd8,
      OP_SW   = 4'd9,
      OP_FSWS = 4'd10
   } op_t;

   // mask/wdata arrive right-justified; the unit lanes them by addr[1:0].
   typedef struct packed {
      logic [31:0] addr;
      logic        load;
      logic        store;
      logic [3:0]  mask;
      logic [31:0] wdata;
   } mem_req_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } lsu_state_t;

   typedef struct packed {
      logic        valid;
      logic        we;
      logic [3:0]  mask;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_bus_req_t;

   typedef struct packed {
      logic        valid;
      logic        err;
      logic [31:0] rdata;
   } lsu_bus_resp_t;

   function automatic logic [31:0] word_addr(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it
// according to the load micro-op; non-load ops yield zero.
module load_align
   import load_store_unit_pkg::*;
(
   input  op_t         op,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = 8'h00;
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      data = '0;
      case (op)
         OP_LB:         data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:        data = {24'h0, byte_sel};
         OP_LH:         data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:        data = {16'h0, half_sel};
         OP_LW, OP_FLWS: data = rdata;
         default:       data = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one access from execute, runs one
// bus request/response, and reports an aligned result or an access fault.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  op_t         op,
   input  mem_req_t    mem_req,
   output logic        lsu_busy,
   output logic        result_valid,
   output logic [31:0] load_data,
   output logic        load_fault,
   output logic        store_fault,
   output logic [31:0] fault_addr,
   output logic        bus_req_valid,
   input  logic        bus_req_ready,
   output logic [31:0] bus_addr,
   output logic        bus_we,
   output logic [3:0]  bus_mask,
   output logic [31:0] bus_wdata,
   input  logic        bus_resp_valid,
   input  logic [31:0] bus_rdata,
   input  logic        bus_resp_err,
   output lsu_state_t  lsu_state
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

   lsu_state_t    state_q;
   logic [7:0]    cnt_q;
   logic [31:0]   addr_q;
   op_t           op_q;
   logic          is_load_q;
   logic          is_store_q;
   lsu_bus_req_t  bus_req_q;
   logic          result_valid_q;
   logic [31:0]   load_data_q;
   logic          load_fault_q;
   logic          store_fault_q;
   logic [31:0]   fault_addr_q;

   lsu_bus_resp_t resp;
   logic          accept;
   logic          timeout_hit;
   logic [3:0]    mask_aligned;
   logic [31:0]   wdata_aligned;
   logic [31:0]   aligned_d;

   assign resp          = '{valid: bus_resp_valid, err: bus_resp_err, rdata: bus_rdata};
   assign accept        = ~rst & ((state_q == ST_IDLE) | (state_q == ST_DONE))
                        & (mem_req.load | mem_req.store) & ~flush;
   assign timeout_hit   = (cnt_q == TMO_LAST);
   assign mask_aligned  = mem_req.mask << mem_req.addr[1:0];
   assign wdata_aligned = mem_req.wdata << {mem_req.addr[1:0], 3'b000};

   load_align u_align (
      .op      (op_q),
      .addr_lo (addr_q[1:0]),
      .rdata   (resp.rdata),
      .data    (aligned_d)
   );

   // Bus request: bus_req_valid and all bus_* fields stay constant from entry
   // into REQ until the cycle bus_req_ready is sampled high (or a flush drops it);
   // a response is only honoured while an access is in WAIT or DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         addr_q         <= '0;
         op_q           <= OP_NOP;
         is_load_q      <= 1'b0;
         is_store_q     <= 1'b0;
         bus_req_q      <= '0;
         result_valid_q <= 1'b0;
         load_data_q    <= '0;
         load_fault_q   <= 1'b0;
         store_fault_q  <= 1'b0;
         fault_addr_q   <= '0;
      end else begin
         result_valid_q <= 1'b0;
         load_data_q    <= '0;
         load_fault_q   <= 1'b0;
         store_fault_q  <= 1'b0;
         fault_addr_q   <= '0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  addr_q     <= mem_req.addr;
                  op_q       <= op;
                  is_load_q  <= mem_req.load;
                  is_store_q <= mem_req.store;
                  bus_req_q  <= '{valid: 1'b1, we: mem_req.store, mask: mask_aligned,
                                 addr: word_addr(mem_req.addr), wdata: wdata_aligned};
                  state_q    <= ST_REQ;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_REQ: begin
               if (flush) begin
                  bus_req_q <= '0;
                  cnt_q     <= '0;
                  state_q   <= bus_req_ready ? ST_DRAIN : ST_IDLE;
               end else if (bus_req_ready) begin
                  bus_req_q <= '0;
                  cnt_q     <= '0;
                  state_q   <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (flush) begin
                  // A response coincident with the flush is already the drained one.
                  state_q <= (resp.valid | timeout_hit) ? ST_IDLE : ST_DRAIN;
                  cnt_q   <= cnt_q + 8'd1;
               end else if (resp.valid | timeout_hit) begin
                  state_q        <= ST_DONE;
                  result_valid_q <= 1'b1;
                  if (~resp.valid | resp.err) begin
                     load_fault_q  <= is_load_q;
                     store_fault_q <= is_store_q;
                     fault_addr_q  <= addr_q;
                  end else if (is_load_q) begin
                     load_data_q <= aligned_d;
                  end
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            ST_DRAIN: begin
               if (resp.valid | timeout_hit) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign lsu_busy      = (state_q == ST_REQ) | (state_q == ST_WAIT) | (state_q == ST_DRAIN) | accept;
   assign result_valid  = result_valid_q;
   assign load_data     = load_data_q;
   assign load_fault    = load_fault_q;
   assign store_fault   = store_fault_q;
   assign fault_addr    = fault_addr_q;
   assign bus_req_valid = bus_req_q.valid;
   assign bus_addr      = bus_req_q.addr;
   assign bus_we        = bus_req_q.we;
   assign bus_mask      = bus_req_q.mask;
   assign bus_wdata     = bus_req_q.wdata;
   assign lsu_state     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stimulus pushes hand-computed bus requests
// and results into queues; negedge monitors pop and compare on each handshake/result.
module tb_load_store_unit;
   import load_store_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   op_t         op;
   mem_req_t    mem_req;
   logic        lsu_busy, result_valid, load_fault, store_fault;
   logic [31:0] load_data, fault_addr;
   logic        bus_req_valid, bus_req_ready, bus_we;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_mask;
   logic        bus_resp_valid, bus_resp_err;
   lsu_state_t  lsu_state;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [65:0] exp_res_q[$];
   logic [68:0] exp_bus_q[$];

   load_store_unit #(.TIMEOUT_CYCLES(255)) dut (
      .clk(clk), .rst(rst), .flush(flush), .op(op), .mem_req(mem_req),
      .lsu_busy(lsu_busy), .result_valid(result_valid), .load_data(load_data),
      .load_fault(load_fault), .store_fault(store_fault), .fault_addr(fault_addr),
      .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
      .bus_we(bus_we), .bus_mask(bus_mask), .bus_wdata(bus_wdata),
      .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata), .bus_resp_err(bus_resp_err),
      .lsu_state(lsu_state)
   );

   // clock / reset support
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   task automatic check_bit(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [68:0] act, input logic [68:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%018h expected 0x%018h", name, act, exp);
      end
   endtask

   function automatic logic [68:0] bus_e(input logic we, input logic [3:0] m,
                                         input logic [31:0] a, input logic [31:0] wd);
      return {we, m, a, wd};
   endfunction

   function automatic logic [65:0] res_e(input logic lf, input logic sf,
                                         input logic [31:0] fa, input logic [31:0] ld);
      return {lf, sf, fa, ld};
   endfunction

   // scoreboard monitors
   always @(negedge clk) begin
      if (!rst && result_valid) begin
         if (exp_res_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected result_valid: load_data=0x%08h fault_addr=0x%08h", load_data, fault_addr);
         end else begin
            check_wide("result", {3'b000, load_fault, store_fault, fault_addr, load_data},
                       {3'b000, exp_res_q.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && bus_req_valid && bus_req_ready) begin
         if (exp_bus_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected bus handshake: addr=0x%08h", bus_addr);
         end else begin
            check_wide("bus_req", {bus_we, bus_mask, bus_addr, bus_wdata}, exp_bus_q.pop_front());
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input op_t o, input logic [31:0] a, input logic ld, input logic st,
                            input logic [3:0] m, input logic [31:0] wd);
      op      = o;
      mem_req = '{addr: a, load: ld, store: st, mask: m, wdata: wd};
   endtask

   task automatic clear_req();
      op      = OP_NOP;
      mem_req = '0;
   endtask

   // Called just after the edge that entered REQ; returns just after the edge into DONE.
   task automatic run_bus(input int rdly, input int wdly, input logic [31:0] rd, input logic err);
      for (int i = 0; i < rdly; i++) begin
         check_bit("stall bus_req_valid", bus_req_valid, 1'b1);
         check_bit("stall lsu_busy", lsu_busy, 1'b1);
         if (exp_bus_q.size() > 0)
            check_wide("stall bus fields", {bus_we, bus_mask, bus_addr, bus_wdata}, exp_bus_q[0]);
         tick();
      end
      bus_req_ready = 1'b1;
      tick();
      bus_req_ready = 1'b0;
      for (int i = 0; i < wdly; i++) begin
         check_bit("wait lsu_busy", lsu_busy, 1'b1);
         tick();
      end
      bus_resp_valid = 1'b1;
      bus_rdata      = rd;
      bus_resp_err   = err;
      tick();
      bus_resp_valid = 1'b0;
      bus_rdata      = '0;
      bus_resp_err   = 1'b0;
   endtask

   task automatic do_access(input op_t o, input logic [31:0] a, input logic ld, input logic st,
                            input logic [3:0] m, input logic [31:0] wd, input int rdly,
                            input int wdly, input logic [31:0] rd, input logic err);
      int c0;
      drive_req(o, a, ld, st, m, wd);
      #1;
      check_bit("accept lsu_busy", lsu_busy, 1'b1);
      c0 = cyc;
      tick();
      clear_req();
      run_bus(rdly, wdly, rd, err);
      check_bit("done result_valid", result_valid, 1'b1);
      check32("latency", 32'(cyc - c0), 32'(3 + rdly + wdly));
      check_bit("done lsu_busy", lsu_busy, 1'b0);
      tick();
      check32("back to idle", 32'(lsu_state), 32'(ST_IDLE));
   endtask

   initial begin
      int wait_cnt;
      rst = 1'b1; flush = 1'b0; clear_req();
      bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_rdata = '0; bus_resp_err = 1'b0;
      repeat (3) tick();
      check_bit("reset lsu_busy", lsu_busy, 1'b0);
      check_bit("reset result_valid", result_valid, 1'b0);
      check_bit("reset faults", load_fault | store_fault, 1'b0);
      check_bit("reset bus_req_valid", bus_req_valid, 1'b0);
      check32("reset load_data", load_data, 32'h0);
      check32("reset fault_addr", fault_addr, 32'h0);
      check32("reset bus_addr", bus_addr, 32'h0);
      check32("reset state", 32'(lsu_state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();

      // sign/zero extended loads and raw word loads
      exp_bus_q.push_back(bus_e(1'b0, 4'b1000, 32'h100, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'hFFFFFF80));
      do_access(OP_LB, 32'h103, 1'b1, 1'b0, 4'b0001, 32'h0, 0, 0, 32'h80112233, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1000, 32'h100, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h00000080));
      do_access(OP_LBU, 32'h103, 1'b1, 1'b0, 4'b0001, 32'h0, 1, 2, 32'h80112233, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1100, 32'h100, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'hFFFF8011));
      do_access(OP_LH, 32'h102, 1'b1, 1'b0, 4'b0011, 32'h0, 0, 1, 32'h80112233, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b0011, 32'h100, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h00002233));
      do_access(OP_LHU, 32'h100, 1'b1, 1'b0, 4'b0011, 32'h0, 0, 0, 32'h80112233, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h104, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'hCAFEF00D));
      do_access(OP_LW, 32'h104, 1'b1, 1'b0, 4'b1111, 32'h0, 0, 0, 32'hCAFEF00D, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h108, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h3F800000));
      do_access(OP_FLWS, 32'h108, 1'b1, 1'b0, 4'b1111, 32'h0, 0, 0, 32'h3F800000, 1'b0);

      // stores: lane shifting, 5-cycle ready stall, load_data forced to zero
      exp_bus_q.push_back(bus_e(1'b1, 4'b1100, 32'h200, 32'hABCD0000));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h0));
      do_access(OP_SH, 32'h202, 1'b0, 1'b1, 4'b0011, 32'h0000ABCD, 5, 0, 32'hFFFFFFFF, 1'b0);
      exp_bus_q.push_back(bus_e(1'b1, 4'b0010, 32'h0, 32'h0000EE00));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h0));
      do_access(OP_SB, 32'h001, 1'b0, 1'b1, 4'b0001, 32'h000000EE, 0, 0, 32'hFFFFFFFF, 1'b0);

      // bus errors
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h400, 32'h0));
      exp_res_q.push_back(res_e(1'b1, 1'b0, 32'h400, 32'h0));
      do_access(OP_LW, 32'h400, 1'b1, 1'b0, 4'b1111, 32'h0, 0, 0, 32'h99999999, 1'b1);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1000, 32'h400, 32'h0));
      exp_res_q.push_back(res_e(1'b1, 1'b0, 32'h403, 32'h0));
      do_access(OP_LB, 32'h403, 1'b1, 1'b0, 4'b0001, 32'h0, 0, 0, 32'h99999999, 1'b1);
      exp_bus_q.push_back(bus_e(1'b1, 4'b1111, 32'h404, 32'h11223344));
      exp_res_q.push_back(res_e(1'b0, 1'b1, 32'h404, 32'h0));
      do_access(OP_SW, 32'h404, 1'b0, 1'b1, 4'b1111, 32'h11223344, 0, 0, 32'h0, 1'b1);

      // timeout: no response at all
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h400, 32'h0));
      exp_res_q.push_back(res_e(1'b1, 1'b0, 32'h400, 32'h0));
      drive_req(OP_LW, 32'h400, 1'b1, 1'b0, 4'b1111, 32'h0);
      tick(); clear_req();
      bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
      wait_cnt = 0;
      for (int i = 0; i < 400 && !result_valid; i++) begin
         if (lsu_state == ST_WAIT) wait_cnt++;
         tick();
      end
      check_bit("timeout result_valid", result_valid, 1'b1);
      check32("timeout wait cycles", 32'(wait_cnt), 32'd255);
      tick();

      // flush in WAIT: drain, discard, then a fresh access goes through
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h300, 32'h0));
      drive_req(OP_LW, 32'h300, 1'b1, 1'b0, 4'b1111, 32'h0);
      tick(); clear_req();
      bus_req_ready = 1'b1; tick(); bus_req_ready = 1'b0;
      flush = 1'b1; tick(); flush = 1'b0;
      check32("flush wait -> drain", 32'(lsu_state), 32'(ST_DRAIN));
      check_bit("drain lsu_busy", lsu_busy, 1'b1);
      tick();
      check_bit("drain no result", result_valid, 1'b0);
      bus_resp_valid = 1'b1; bus_rdata = 32'hDEADBEEF; tick();
      bus_resp_valid = 1'b0; bus_rdata = '0;
      check32("drain -> idle", 32'(lsu_state), 32'(ST_IDLE));
      check_bit("drain discard", result_valid, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h304, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h12345678));
      do_access(OP_LW, 32'h304, 1'b1, 1'b0, 4'b1111, 32'h0, 0, 0, 32'h12345678, 1'b0);

      // flush in REQ before handshake, and coincident with ready
      drive_req(OP_LW, 32'h600, 1'b1, 1'b0, 4'b1111, 32'h0);
      tick(); clear_req();
      flush = 1'b1; tick(); flush = 1'b0;
      check32("flush req -> idle", 32'(lsu_state), 32'(ST_IDLE));
      check_bit("flush req drops valid", bus_req_valid, 1'b0);
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h700, 32'h0));
      drive_req(OP_LW, 32'h700, 1'b1, 1'b0, 4'b1111, 32'h0);
      tick(); clear_req();
      flush = 1'b1; bus_req_ready = 1'b1; tick(); flush = 1'b0; bus_req_ready = 1'b0;
      check32("flush+ready -> drain", 32'(lsu_state), 32'(ST_DRAIN));
      bus_resp_valid = 1'b1; bus_rdata = 32'h77777777; tick();
      bus_resp_valid = 1'b0; bus_rdata = '0;
      check32("drain2 -> idle", 32'(lsu_state), 32'(ST_IDLE));

      // flush in IDLE blocks accept; stray response in IDLE is ignored
      flush = 1'b1;
      drive_req(OP_LW, 32'h800, 1'b1, 1'b0, 4'b1111, 32'h0);
      #1;
      check_bit("flush idle no busy", lsu_busy, 1'b0);
      tick(); flush = 1'b0; clear_req();
      check32("flush idle stays idle", 32'(lsu_state), 32'(ST_IDLE));
      bus_resp_valid = 1'b1; bus_rdata = 32'h5A5A5A5A; tick();
      bus_resp_valid = 1'b0; bus_rdata = '0;
      check32("stray resp stays idle", 32'(lsu_state), 32'(ST_IDLE));
      tick();

      // back-to-back LW then SW issued in DONE
      exp_bus_q.push_back(bus_e(1'b0, 4'b1111, 32'h500, 32'h0));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h0BADF00D));
      exp_bus_q.push_back(bus_e(1'b1, 4'b1111, 32'h504, 32'h55AA55AA));
      exp_res_q.push_back(res_e(1'b0, 1'b0, 32'h0, 32'h0));
      drive_req(OP_LW, 32'h500, 1'b1, 1'b0, 4'b1111, 32'h0);
      tick(); clear_req();
      run_bus(0, 0, 32'h0BADF00D, 1'b0);
      drive_req(OP_SW, 32'h504, 1'b0, 1'b1, 4'b1111, 32'h55AA55AA);
      #1;
      check_bit("b2b result_valid", result_valid, 1'b1);
      check_bit("b2b accept busy", lsu_busy, 1'b1);
      tick(); clear_req();
      check32("b2b no bubble", 32'(lsu_state), 32'(ST_REQ));
      run_bus(0, 0, 32'h0, 1'b0);
      check_bit("b2b second result", result_valid, 1'b1);
      tick();

      // reset mid-transaction abandons the access
      drive_req(OP_LW, 32'h900, 1'b1, 1'b0, 4'b1111, 32'h0);
      tick(); clear_req();
      rst = 1'b1; tick(); rst = 1'b0;
      check32("mid reset state", 32'(lsu_state), 32'(ST_IDLE));
      check_bit("mid reset bus_req_valid", bus_req_valid, 1'b0);
      tick();

      check32("result queue drained", 32'(exp_res_q.size()), 32'd0);
      check32("bus queue drained", 32'(exp_bus_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset: clk (input) and rst (input), with all state updated on posedge clk.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum WAIT cycles before an access fault (8-bit counter).
REQ-003 The block SHALL have the following ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash current access
- op  in  op_t  micro-op of the issuing instruction
- mem_req  in  mem_req_t  addr/load/store/mask/wdata from execute
- lsu_busy  out  1  stall execute
- result_valid  out  1  one-cycle completion pulse
- load_data  out  32  aligned, extended load result
- load_fault  out  1  load access fault
- store_fault  out  1  store access fault
- fault_addr  out  32  faulting address
- bus_req_valid  out  1  bus request valid
- bus_req_ready  in  1  bus accepts request
- bus_addr  out  32  word-aligned address {addr[31:2],2'b0}
- bus_we  out  1  write enable
- bus_mask  out  4  byte enables
- bus_wdata  out  32  write data
- bus_resp_valid  in  1  response valid
- bus_rdata  in  32  read data
- bus_resp_err  in  1  bus error

Function
REQ-004 States SHALL be IDLE, REQ, WAIT, DONE, DRAIN.
REQ-005 In IDLE or DONE, a cycle with (mem_req.load|mem_req.store) & ~flush SHALL latch addr, mask, wdata, op and load/store, then go to REQ.
REQ-006 In that accept cycle, lsu_busy SHALL be asserted combinationally.
REQ-007 In REQ, bus_req_valid SHALL be 1 with bus_* driven from the latched fields, and these SHALL hold stable until bus_req_ready.
REQ-008 REQ with bus_req_ready SHALL transition to WAIT and clear the timeout counter.
REQ-009 In WAIT, bus_resp_valid SHALL latch the result and transition to DONE, and the fault is flagged if bus_resp_err.
REQ-010 If the counter reaches TIMEOUT_CYCLES without a response, WAIT SHALL transition to DONE with a fault.
REQ-011 DONE SHALL last exactly 1 cycle with result_valid=1 and lsu_busy=0 unless a new request is accepted; DONE then goes to REQ if a request is accepted, else to IDLE.
REQ-012 lsu_busy SHALL be 1 in REQ, WAIT and DRAIN.
REQ-013 Load latency SHALL be minimum 3 cycles from accept to result_valid (accept, REQ with ready, response in WAIT, then DONE).
REQ-014 Load extension: LB/LBU SHALL select byte addr[1:0] with sign/zero extension; LH/LHU SHALL select half addr[1] with sign/zero extension; LW/FLWS SHALL pass raw.
REQ-015 For stores, load_data SHALL be 0.
REQ-016 In DONE with a fault, load_fault or store_fault SHALL equal the op kind, fault_addr SHALL be the latched addr, and load_data SHALL be 0; otherwise fault_addr=0.
REQ-017 Flush in IDLE or DONE SHALL cause no accept.
REQ-018 Flush in REQ before the handshake SHALL go to IDLE; flush in REQ coincident with bus_req_ready SHALL go to DRAIN.
REQ-019 Flush in WAIT SHALL go to DRAIN, and DRAIN SHALL wait for bus_resp_valid or timeout, discard the result, and go to IDLE.
REQ-020 result_valid SHALL never assert for a flushed access.
REQ-021 bus_resp_valid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-022 Reset SHALL force IDLE with every output 0, the counter 0 and the latched fields 0.
REQ-023 Reset mid-transaction SHALL abandon it without a drain; the bus owner is reset by the same rst.

Structure
REQ-024 lsu_state_t, lsu_bus_req_t and lsu_bus_resp_t SHALL live in package bundle alongside mem_req_t.
REQ-025 Combinational alignment/extension SHALL be sub-module load_align (op, addr[1:0], rdata -> data).

Verification
REQ-026 LB at addr 0x103 with rdata 0x80112233 -> after 3 cycles result_valid=1, load_data=0xFFFFFF80; LBU gives 0x00000080.
REQ-027 SH at addr 0x202 with rs2 0x0000ABCD -> bus_addr=0x200, bus_mask=1100, bus_wdata=0xABCD0000, bus_we=1; result_valid with load_data=0.
REQ-028 bus_req_ready held low 5 cycles -> bus_* stable and lsu_busy=1 throughout; completion follows ready.
REQ-029 LW at 0x300 with flush in WAIT then response 0xDEADBEEF -> no result_valid; DRAIN then IDLE; the next request is accepted.
REQ-030 LW at 0x400 with bus_resp_err=1 -> load_fault=1, fault_addr=0x400; with no response -> fault after 255 WAIT cycles.
REQ-031 Back-to-back LW/SW issued in DONE -> second accepted same cycle, with no idle bubble.
